// File: rtl/fold_lane_pkg.sv
// Shared types and elaboration helpers for the fold_lane_array slice.
// Optional feature macro: FOLD_LANE_ARRAY_PARITY_EN (adds per-lane parity output).
package fold_lane_pkg;

    typedef enum logic {
        LANE_IDLE = 1'b0,
        LANE_RUN  = 1'b1
    } lane_state_t;

    // Number of serial fold steps needed to consume one lane slice.
    function automatic int chunks(input int in_w, input int out_w);
        return (out_w > 0) ? (in_w / out_w) : 0;
    endfunction

    // Legal geometry: at least one lane, non-empty output, input an exact multiple of output.
    function automatic bit params_ok(input int lanes, input int in_w, input int out_w);
        return (lanes >= 1) && (out_w >= 1) && (in_w >= out_w) && ((in_w % out_w) == 0);
    endfunction

endpackage

// File: rtl/fold_lane.sv
// One lane engine: serially XOR-folds a LANE_IN_W slice down to LANE_OUT_W bits,
// one chunk per cycle, and publishes the result when the last chunk is consumed.
// Optional feature macro: FOLD_LANE_ARRAY_PARITY_EN (adds the parity output).
module fold_lane
    import fold_lane_pkg::*;
#(
    parameter int LANE_IN_W  = 16,
    parameter int LANE_OUT_W = 4
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  accept,
    input  logic                  en,
    input  logic [LANE_IN_W-1:0]  slice,
    output logic                  busy,
    output logic                  done,
`ifdef FOLD_LANE_ARRAY_PARITY_EN
    output logic                  parity,
`endif
    output logic [LANE_OUT_W-1:0] dout
);

    localparam int CHUNKS = chunks(LANE_IN_W, LANE_OUT_W);
    localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHUNKS - 1);

    lane_state_t           state_reg;
    lane_state_t           state_next;
    logic [LANE_IN_W-1:0]  sreg_reg;
    logic [LANE_OUT_W-1:0] acc_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic [LANE_OUT_W-1:0] dout_reg;
    logic [LANE_OUT_W-1:0] chunk;
    logic                  last_chunk;

    assign chunk      = sreg_reg[LANE_OUT_W-1:0];
    assign last_chunk = (cnt_reg == CNT_LAST);
    assign dout       = dout_reg;

    // State register
    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg <= LANE_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state: a disabled lane never leaves IDLE
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            LANE_IDLE: if (accept && en) state_next = LANE_RUN;
            LANE_RUN:  if (last_chunk)   state_next = LANE_IDLE;
            default:                     state_next = LANE_IDLE;
        endcase
    end

    // Outputs: busy for the whole RUN phase, done on the final fold cycle
    always_comb begin
        busy = (state_reg == LANE_RUN);
        done = (state_reg == LANE_RUN) && last_chunk;
    end

    // Datapath: load on accept, fold one chunk per cycle, publish on the last chunk
    always_ff @(posedge clk) begin
        if (srst) begin
            sreg_reg <= '0;
            acc_reg  <= '0;
            cnt_reg  <= '0;
            dout_reg <= '0;
        end else if (state_reg == LANE_IDLE && accept) begin
            if (en) begin
                sreg_reg <= slice;
                acc_reg  <= '0;
                cnt_reg  <= '0;
            end else begin
                dout_reg <= '0;
            end
        end else if (state_reg == LANE_RUN) begin
            if (last_chunk) begin
                dout_reg <= acc_reg ^ chunk;
            end else begin
                acc_reg  <= acc_reg ^ chunk;
                sreg_reg <= sreg_reg >> LANE_OUT_W;
                cnt_reg  <= cnt_reg + CNT_W'(1);
            end
        end
    end

`ifdef FOLD_LANE_ARRAY_PARITY_EN
    logic par_latched_reg;
    logic parity_reg;

    assign parity = parity_reg;

    // Parity of the latched slice, published together with the fold result
    always_ff @(posedge clk) begin
        if (srst) begin
            par_latched_reg <= 1'b0;
            parity_reg      <= 1'b0;
        end else if (state_reg == LANE_IDLE && accept) begin
            if (en) begin
                par_latched_reg <= ^slice;
            end else begin
                parity_reg <= 1'b0;
            end
        end else if (done) begin
            parity_reg <= par_latched_reg;
        end
    end
`endif

endmodule

// File: rtl/fold_lane_array.sv
// Multi-lane XOR-fold reduction: splits DATA_IN into LANES slices, folds each in
// its own fold_lane engine, and aggregates the start/done handshake and BUSY.
// Optional feature macro: FOLD_LANE_ARRAY_PARITY_EN (adds PARITY_OUT).
module fold_lane_array
    import fold_lane_pkg::*;
#(
    parameter int LANES      = 2,
    parameter int LANE_IN_W  = 16,
    parameter int LANE_OUT_W = 4
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        START,
    input  logic [LANES-1:0]            LANE_EN,
    input  logic [LANES*LANE_IN_W-1:0]  DATA_IN,
    output logic [LANES*LANE_OUT_W-1:0] DATA_OUT,
    output logic                        BUSY,
    output logic                        DONE,
`ifdef FOLD_LANE_ARRAY_PARITY_EN
    output logic [LANES-1:0]            PARITY_OUT,
`endif
    output logic                        OVERRUN
);

    if (!params_ok(LANES, LANE_IN_W, LANE_OUT_W)) begin : g_bad_params
        $error("fold_lane_array: illegal geometry LANES=%0d LANE_IN_W=%0d LANE_OUT_W=%0d",
               LANES, LANE_IN_W, LANE_OUT_W);
    end

    logic             accept;
    logic [LANES-1:0] lane_busy;
    logic [LANES-1:0] lane_done;
    logic [LANES-1:0] en_reg;
    logic             op_active_reg;
    logic             done_reg;
    logic             overrun_reg;
    logic             all_done;

    assign accept   = START && !BUSY;
    assign BUSY     = |lane_busy;
    // Lanes that were not enabled count as already finished
    assign all_done = &(lane_done | ~en_reg);
    assign DONE     = done_reg;
    assign OVERRUN  = overrun_reg;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        fold_lane #(
            .LANE_IN_W  (LANE_IN_W),
            .LANE_OUT_W (LANE_OUT_W)
        ) u_lane (
            .clk    (CLK),
            .srst   (RST),
            .accept (accept),
            .en     (LANE_EN[gi]),
            .slice  (DATA_IN[gi*LANE_IN_W +: LANE_IN_W]),
            .busy   (lane_busy[gi]),
            .done   (lane_done[gi]),
`ifdef FOLD_LANE_ARRAY_PARITY_EN
            .parity (PARITY_OUT[gi]),
`endif
            .dout   (DATA_OUT[gi*LANE_OUT_W +: LANE_OUT_W])
        );
    end

    // Operation tracking: DONE fires once all enabled lanes finish; a new accept wins over clearing
    always_ff @(posedge CLK) begin
        if (RST) begin
            en_reg        <= '0;
            op_active_reg <= 1'b0;
            done_reg      <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            done_reg <= op_active_reg && all_done;
            if (START && BUSY) begin
                overrun_reg <= 1'b1;
            end
            if (accept) begin
                op_active_reg <= 1'b1;
                en_reg        <= LANE_EN;
            end else if (op_active_reg && all_done) begin
                op_active_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fold_lane_array.sv
// Self-checking bench for fold_lane_array: directed test-plan cases plus random
// operations, checked against a column-wise XOR reference model.
// Optional feature macro: FOLD_LANE_ARRAY_PARITY_EN (parity output checked when defined).
module tb_fold_lane_array;

    localparam int LANES      = 2;
    localparam int LANE_IN_W  = 16;
    localparam int LANE_OUT_W = 4;
    localparam int CHUNKS     = LANE_IN_W / LANE_OUT_W;
    localparam int IN_W       = LANES * LANE_IN_W;
    localparam int OUT_W      = LANES * LANE_OUT_W;

    localparam int L4         = 4;
    localparam int L4_IN      = 8;
    localparam int L4_OUT     = 2;
    localparam int L4_CHUNKS  = L4_IN / L4_OUT;

    logic clk = 1'b0;
    logic rst;

    logic             start;
    logic [LANES-1:0] lane_en;
    logic [IN_W-1:0]  data_in;
    logic [OUT_W-1:0] data_out;
    logic             busy, done, overrun;

    logic                start4;
    logic [L4-1:0]       lane_en4;
    logic [L4*L4_IN-1:0] data_in4;
    logic [L4*L4_OUT-1:0] data_out4;
    logic                busy4, done4, overrun4;

`ifdef FOLD_LANE_ARRAY_PARITY_EN
    logic [LANES-1:0] parity_out;
    logic [L4-1:0]    parity_out4;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fold_lane_array #(
        .LANES (LANES), .LANE_IN_W (LANE_IN_W), .LANE_OUT_W (LANE_OUT_W)
    ) u_dut (
        .CLK (clk), .RST (rst), .START (start), .LANE_EN (lane_en),
        .DATA_IN (data_in), .DATA_OUT (data_out), .BUSY (busy), .DONE (done),
`ifdef FOLD_LANE_ARRAY_PARITY_EN
        .PARITY_OUT (parity_out),
`endif
        .OVERRUN (overrun)
    );

    fold_lane_array #(
        .LANES (L4), .LANE_IN_W (L4_IN), .LANE_OUT_W (L4_OUT)
    ) u_dut4 (
        .CLK (clk), .RST (rst), .START (start4), .LANE_EN (lane_en4),
        .DATA_IN (data_in4), .DATA_OUT (data_out4), .BUSY (busy4), .DONE (done4),
`ifdef FOLD_LANE_ARRAY_PARITY_EN
        .PARITY_OUT (parity_out4),
`endif
        .OVERRUN (overrun4)
    );

    // Result bit b of a lane is the XOR of bit b of every chunk in its slice.
    function automatic logic [63:0] model_out(input int lanes, input int in_w, input int out_w,
                                              input logic [63:0] en, input logic [63:0] din);
        logic [63:0] r;
        logic        a;
        r = '0;
        for (int l = 0; l < lanes; l++) begin
            if (en[l]) begin
                for (int b = 0; b < out_w; b++) begin
                    a = 1'b0;
                    for (int c = 0; c < in_w / out_w; c++) a ^= din[l*in_w + c*out_w + b];
                    r[l*out_w + b] = a;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [63:0] model_parity(input int lanes, input int in_w,
                                                 input logic [63:0] en, input logic [63:0] din);
        logic [63:0] r;
        r = '0;
        for (int l = 0; l < lanes; l++) begin
            if (en[l]) begin
                for (int b = 0; b < in_w; b++) r[l] ^= din[l*in_w + b];
            end
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One accepted operation on the 2-lane instance, with latency/busy/done bookkeeping.
    task automatic run_op(input string tag, input logic [LANES-1:0] en, input logic [IN_W-1:0] din);
        logic [63:0] exp_out, exp_par;
        int exp_lat, busy_cnt, done_cnt, done_at;
        exp_out = model_out(LANES, LANE_IN_W, LANE_OUT_W, 64'(en), 64'(din));
        exp_par = model_parity(LANES, LANE_IN_W, 64'(en), 64'(din));
        exp_lat = (en == '0) ? 1 : CHUNKS;
        start = 1'b1; lane_en = en; data_in = din;
        step();
        start = 1'b0; lane_en = LANES'($urandom); data_in = IN_W'($urandom);
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        for (int c = 0; c < CHUNKS + 3; c++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
                check({tag, "_dout"}, 64'(data_out), exp_out);
`ifdef FOLD_LANE_ARRAY_PARITY_EN
                check({tag, "_parity"}, 64'(parity_out), exp_par);
`endif
            end
            step();
        end
        check({tag, "_busy_cycles"}, 64'(busy_cnt), (en == '0) ? 64'd0 : 64'(CHUNKS));
        check({tag, "_done_count"}, 64'(done_cnt), 64'd1);
        check({tag, "_latency"}, 64'(done_at), 64'(exp_lat));
        check({tag, "_dout_hold"}, 64'(data_out), exp_out);
        $display("[TB] op %s en=%b din=%h dout=%h exp=%h lat=%0d", tag, en, din, data_out,
                 exp_out[OUT_W-1:0], done_at);
    endtask

    // Same procedure for the 4-lane, 8-to-2 instance.
    task automatic run_op4(input string tag, input logic [L4-1:0] en, input logic [L4*L4_IN-1:0] din);
        logic [63:0] exp_out;
        int exp_lat, busy_cnt, done_cnt, done_at;
        exp_out = model_out(L4, L4_IN, L4_OUT, 64'(en), 64'(din));
        exp_lat = (en == '0) ? 1 : L4_CHUNKS;
        start4 = 1'b1; lane_en4 = en; data_in4 = din;
        step();
        start4 = 1'b0; lane_en4 = L4'($urandom); data_in4 = $urandom;
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        for (int c = 0; c < L4_CHUNKS + 3; c++) begin
            if (busy4) busy_cnt++;
            if (done4) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
                check({tag, "_dout"}, 64'(data_out4), exp_out);
`ifdef FOLD_LANE_ARRAY_PARITY_EN
                check({tag, "_parity"}, 64'(parity_out4),
                      model_parity(L4, L4_IN, 64'(en), 64'(din)));
`endif
            end
            step();
        end
        check({tag, "_busy_cycles"}, 64'(busy_cnt), (en == '0) ? 64'd0 : 64'(L4_CHUNKS));
        check({tag, "_done_count"}, 64'(done_cnt), 64'd1);
        check({tag, "_latency"}, 64'(done_at), 64'(exp_lat));
        $display("[TB] op4 %s en=%b din=%h dout=%h exp=%h lat=%0d", tag, en, din, data_out4,
                 exp_out[L4*L4_OUT-1:0], done_at);
    endtask

    initial begin
        logic [IN_W-1:0] d1, d2;
        int done_seen;

        rst = 1'b1; start = 1'b0; lane_en = '0; data_in = '0;
        start4 = 1'b0; lane_en4 = '0; data_in4 = '0;
        step(); step();
        rst = 1'b0;
        step();
        check("reset_dout", 64'(data_out), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_overrun", 64'(overrun), 64'd0);
        $display("[TB] reset released dout=%h busy=%b done=%b overrun=%b", data_out, busy, done, overrun);

        // Directed test-plan cases
        run_op("tp1", 2'b11, 32'h1234_ABCD);
        check("tp1_const", 64'(data_out), 64'h40);
        run_op("tp2", 2'b01, 32'hFFFF_0001);
        check("tp2_const", 64'(data_out), 64'h01);
`ifdef FOLD_LANE_ARRAY_PARITY_EN
        check("tp2_parity_const", 64'(parity_out), 64'h1);
`endif
        run_op("tp3_none", 2'b00, IN_W'($urandom));
        check("tp3_const", 64'(data_out), 64'h00);

        // Random operations
        for (int i = 0; i < 16; i++) begin
            run_op($sformatf("rnd%0d", i), LANES'($urandom), IN_W'($urandom));
        end
        check("no_overrun_yet", 64'(overrun), 64'd0);

        // START held for 10 edges: second accept on the DONE cycle, OVERRUN set
        d1 = IN_W'($urandom); d2 = IN_W'($urandom);
        start = 1'b1; lane_en = 2'b11; data_in = d1;
        step();
        data_in = d2;
        for (int k = 0; k <= 10; k++) begin
            if (k == 4) begin
                check("ovr_done1", 64'(done), 64'd1);
                check("ovr_dout1", 64'(data_out), model_out(LANES, LANE_IN_W, LANE_OUT_W, 64'h3, 64'(d1)));
            end else if (k == 9) begin
                check("ovr_done2", 64'(done), 64'd1);
                check("ovr_dout2", 64'(data_out), model_out(LANES, LANE_IN_W, LANE_OUT_W, 64'h3, 64'(d2)));
            end else begin
                check($sformatf("ovr_nodone_k%0d", k), 64'(done), 64'd0);
            end
            if (k == 5) check("ovr_busy_again", 64'(busy), 64'd1);
            if (k == 9) start = 1'b0;
            step();
        end
        check("ovr_sticky", 64'(overrun), 64'd1);
        $display("[TB] overrun sequence d1=%h d2=%h dout=%h overrun=%b", d1, d2, data_out, overrun);

        // Reset two cycles after accept aborts the operation
        start = 1'b1; lane_en = 2'b11; data_in = IN_W'($urandom);
        step();
        start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_dout", 64'(data_out), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_done", 64'(done), 64'd0);
        check("rst_mid_overrun", 64'(overrun), 64'd0);
        done_seen = 0;
        for (int k = 0; k < CHUNKS + 2; k++) begin
            if (done || busy) done_seen++;
            step();
        end
        check("rst_mid_quiet", 64'(done_seen), 64'd0);
        $display("[TB] mid-op reset dout=%h busy=%b done=%b", data_out, busy, done);
        run_op("post_rst", 2'b11, IN_W'($urandom));

        // 4-lane, 8-to-2 instance
        run_op4("tp6", 4'hF, 32'h0000_00FF);
        check("tp6_lane0", 64'(data_out4[1:0]), 64'd0);
        for (int i = 0; i < 6; i++) begin
            run_op4($sformatf("rnd4_%0d", i), L4'($urandom), $urandom);
        end
        check("dut4_overrun", 64'(overrun4), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
